// File: rtl/sprite_ram_loader.sv
// Sprite pixel RAM (4096 x 12, read-first, registered read) with a byte-stream loader FSM.
// Define SPRITE_LOADER_CHECKSUM_EN to require an XOR trailer byte and report mismatches on load_error.
module sprite_ram_loader #(
  parameter int IMG_W = 48,
  parameter int IMG_H = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pixel_address,
  output logic [11:0] rgb_pixel,
  input  logic        load_start,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {IDLE, BYTE_HI, BYTE_LO, CHECK, DONE} state_t;

  localparam logic [5:0] X_LAST = 6'(IMG_W - 1);
  localparam logic [5:0] Y_LAST = 6'(IMG_H - 1);

  state_t      state;
  logic [5:0]  x, y;
  logic [3:0]  r_lat;
  logic [11:0] mem [4096];
  logic        accept, wr_en, last_px;

  assign accept  = byte_valid && byte_ready;
  assign wr_en   = rst && accept && (state == BYTE_LO);
  assign last_px = (x == X_LAST) && (y == Y_LAST);

  // Memory is deliberately never reset so an aborted load keeps what it wrote.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{y, x}] <= {r_lat, byte_data};
  end

  // Separate read register gives read-first behaviour on same-address collisions.
  always_ff @(posedge clk) begin
    if (!rst) rgb_pixel <= 12'h000;
    else      rgb_pixel <= mem[pixel_address];
  end

`ifdef SPRITE_LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`else
  assign load_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    load_done <= 1'b0;
    if (!rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      r_lat      <= '0;
      byte_ready <= 1'b0;
      load_busy  <= 1'b0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
      checksum   <= '0;
      load_error <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (load_start) begin
          state      <= BYTE_HI;
          x          <= '0;
          y          <= '0;
          byte_ready <= 1'b1;
          load_busy  <= 1'b1;
`ifdef SPRITE_LOADER_CHECKSUM_EN
          checksum   <= '0;
          load_error <= 1'b0;
`endif
        end
        BYTE_HI: if (accept) begin
          r_lat <= byte_data[3:0];
          state <= BYTE_LO;
`ifdef SPRITE_LOADER_CHECKSUM_EN
          checksum <= checksum ^ byte_data;
`endif
        end
        BYTE_LO: if (accept) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
          checksum <= checksum ^ byte_data;
`endif
          if (last_px) begin
            x <= '0;
            y <= '0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
            state      <= CHECK;
`else
            state      <= DONE;
            byte_ready <= 1'b0;
            load_done  <= 1'b1;
`endif
          end else begin
            state <= BYTE_HI;
            if (x == X_LAST) begin
              x <= '0;
              y <= y + 6'd1;
            end else begin
              x <= x + 6'd1;
            end
          end
        end
`ifdef SPRITE_LOADER_CHECKSUM_EN
        CHECK: if (accept) begin
          if (byte_data != checksum) load_error <= 1'b1;
          state      <= DONE;
          byte_ready <= 1'b0;
          load_done  <= 1'b1;
        end
`endif
        DONE: begin
          state     <= IDLE;
          load_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          load_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Scoreboard bench for sprite_ram_loader: full loads, abort, read-first collision, ignored restart.
module tb_sprite_ram_loader;
  localparam int W = 48, H = 64, NPIX = W * H;

  logic        clk = 1'b0, rst = 1'b0;
  logic [11:0] pixel_address = '0;
  logic [11:0] rgb_pixel;
  logic        load_start = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, load_busy, load_done, load_error;

  sprite_ram_loader #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .pixel_address(pixel_address), .rgb_pixel(rgb_pixel),
    .load_start(load_start), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .load_busy(load_busy), .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0, done_cnt = 0;
  logic [11:0] model_mem [4096];
  logic [7:0]  csum = '0;
  logic        exp_err = 1'b0;
  logic [11:0] exp_q [$];

  always @(negedge clk) if (load_done) done_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [11:0] addr_of(input int idx);
    return {6'(idx / W), 6'(idx % W)};
  endfunction

  function automatic logic [11:0] pix(input int n, input logic [11:0] mask);
    logic [11:0] nn;
    nn = 12'(n);
    return {nn[3:0], nn[7:4], nn[11:8]} ^ mask;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int n;
    n = 0;
    repeat ($urandom_range(0, max_gap)) tick();
    byte_data  = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 200) begin tick(); n++; end
    if (!byte_ready) begin
      tests++; fails++;
      $display("FAIL send_byte_timeout byte_ready=%0b required 1", byte_ready);
      byte_valid = 1'b0;
      return;
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_pixel(input int idx, input logic [11:0] p, input int max_gap);
    logic [7:0] hi;
    hi = {4'($urandom), p[11:8]};
    send_byte(hi, max_gap);
    send_byte(p[7:0], max_gap);
    model_mem[addr_of(idx)] = p;
    csum = csum ^ hi ^ p[7:0];
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    csum = '0;
    exp_err = 1'b0;
  endtask

  task automatic finish_load(input logic bad);
`ifdef SPRITE_LOADER_CHECKSUM_EN
    send_byte(csum ^ {7'd0, bad}, 1);
    if (bad) exp_err = 1'b1;
`else
    if (bad) exp_err = 1'b0;
`endif
    repeat (3) tick();
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic read_check(input int first, input int count, input string name);
    exp_q.delete();
    for (int i = 0; i <= count; i++) begin
      if (exp_q.size() > 0) begin
        logic [11:0] e;
        e = exp_q.pop_front();
        tests++;
        if (rgb_pixel !== e) begin
          fails++;
          $display("FAIL %s pixel=%0d got %h expected %h", name, first + i - 1, rgb_pixel, e);
        end
      end
      if (i < count) begin
        pixel_address = addr_of(first + i);
        exp_q.push_back(model_mem[addr_of(first + i)]);
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    tests += 5;
    if (byte_ready !== 1'b0) begin fails++; $display("FAIL reset_byte_ready got %b expected 0", byte_ready); end
    if (load_busy  !== 1'b0) begin fails++; $display("FAIL reset_load_busy got %b expected 0", load_busy); end
    if (load_done  !== 1'b0) begin fails++; $display("FAIL reset_load_done got %b expected 0", load_done); end
    if (load_error !== 1'b0) begin fails++; $display("FAIL reset_load_error got %b expected 0", load_error); end
    if (rgb_pixel  !== 12'h000) begin fails++; $display("FAIL reset_rgb got %h expected 000", rgb_pixel); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_load();
    int d0;
    start_load();
    d0 = done_cnt;
    tests++;
    if (byte_ready !== 1'b1) begin fails++; $display("FAIL full_ready_after_start got %b expected 1", byte_ready); end
    for (int n = 0; n < NPIX; n++) begin
      if (n == NPIX - 1) begin
        tests++;
        if (done_cnt !== d0) begin fails++; $display("FAIL full_early_done got %0d expected %0d", done_cnt, d0); end
      end
      send_pixel(n, pix(n, 12'h000), 2);
    end
    finish_load(1'b0);
    tests += 3;
    if (done_cnt !== d0 + 1) begin fails++; $display("FAIL full_done_count got %0d expected %0d", done_cnt, d0 + 1); end
    if (load_busy !== 1'b0) begin fails++; $display("FAIL full_busy_end got %b expected 0", load_busy); end
    if (load_error !== exp_err) begin fails++; $display("FAIL full_error got %b expected %b", load_error, exp_err); end
    read_check(0, NPIX, "full_read");
  endtask

  task automatic test_checksum();
`ifdef SPRITE_LOADER_CHECKSUM_EN
    start_load();
    for (int n = 0; n < NPIX; n++) send_pixel(n, pix(n, 12'h0F0), 0);
    finish_load(1'b1);
    tests++;
    if (load_error !== 1'b1) begin fails++; $display("FAIL csum_bad_trailer got %b expected 1", load_error); end
    repeat (5) tick();
    tests++;
    if (load_error !== 1'b1) begin fails++; $display("FAIL csum_error_hold got %b expected 1", load_error); end
    start_load();
    tests++;
    if (load_error !== 1'b0) begin fails++; $display("FAIL csum_clear_on_start got %b expected 0", load_error); end
    rst_pulse();
    read_check(0, 64, "csum_read");
`else
    tests++;
    if (load_error !== 1'b0) begin fails++; $display("FAIL csum_tied_low got %b expected 0", load_error); end
`endif
  endtask

  task automatic test_ignore_start();
    int d0;
    start_load();
    d0 = done_cnt;
    for (int n = 0; n < 10; n++) send_pixel(n, pix(n, 12'h555), 1);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tests += 2;
    if (load_busy !== 1'b1) begin fails++; $display("FAIL ignore_busy got %b expected 1", load_busy); end
    if (load_error !== exp_err) begin fails++; $display("FAIL ignore_error got %b expected %b", load_error, exp_err); end
    for (int n = 10; n < NPIX; n++) send_pixel(n, pix(n, 12'h555), 0);
    finish_load(1'b0);
    tests += 3;
    if (done_cnt !== d0 + 1) begin fails++; $display("FAIL ignore_done_count got %0d expected %0d", done_cnt, d0 + 1); end
    if (load_busy !== 1'b0) begin fails++; $display("FAIL ignore_busy_end got %b expected 0", load_busy); end
    if (byte_ready !== 1'b0) begin fails++; $display("FAIL ignore_ready_end got %b expected 0", byte_ready); end
    read_check(0, 200, "ignore_read");
  endtask

  task automatic test_reset_mid_load();
    start_load();
    for (int n = 0; n < 100; n++) send_pixel(n, pix(n, 12'hFFF), 1);
    rst_pulse();
    tests += 2;
    if (load_busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b expected 0", load_busy); end
    if (byte_ready !== 1'b0) begin fails++; $display("FAIL abort_ready got %b expected 0", byte_ready); end
    read_check(0, 200, "abort_read");
  endtask

  task automatic test_read_first();
    start_load();
    for (int n = 0; n < 5; n++) send_pixel(n, pix(n, 12'h0A0), 0);
    send_pixel(5, 12'h123, 0);
    rst_pulse();
    start_load();
    for (int n = 0; n < 5; n++) send_pixel(n, pix(n, 12'h0A0), 0);
    send_byte(8'h0A, 0);
    pixel_address = {6'd0, 6'd5};
    byte_data  = 8'hBC;
    byte_valid = 1'b1;
    tests++;
    if (byte_ready !== 1'b1) begin fails++; $display("FAIL rf_ready got %b expected 1", byte_ready); end
    tick();
    byte_valid = 1'b0;
    model_mem[{6'd0, 6'd5}] = 12'hABC;
    tests++;
    if (rgb_pixel !== 12'h123) begin fails++; $display("FAIL rf_old_value got %h expected 123", rgb_pixel); end
    tick();
    tests++;
    if (rgb_pixel !== 12'hABC) begin fails++; $display("FAIL rf_new_value got %h expected abc", rgb_pixel); end
    rst_pulse();
    read_check(0, 8, "rf_read");
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_checksum();
    test_ignore_start();
    test_reset_mid_load();
    test_read_first();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_ram_loader.md
SPRITE_RAM_LOADER -- requirements
Module: sprite_ram_loader

Interface
REQ-001 Parameter IMG_W, default 48, sprite width in pixels (1..64).
REQ-002 Parameter IMG_H, default 64, sprite height in pixels (1..64).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 pixel_address  input  12  read address {y[5:0], x[5:0]} from the sprite drawer.
REQ-006 rgb_pixel  output  12  pixel {R,G,B} stored at pixel_address.
REQ-007 load_start  input  1  single-cycle request to begin a sprite load.
REQ-008 byte_data  input  8  load stream byte.
REQ-009 byte_valid  input  1  byte_data valid.
REQ-010 byte_ready  output  1  block accepts byte_data this cycle.
REQ-011 load_busy  output  1  load in progress.
REQ-012 load_done  output  1  one-cycle pulse at load completion.
REQ-013 load_error  output  1  sticky checksum mismatch flag (see Configuration).

Function
REQ-014 The block SHALL hold a 4096 x 12 pixel memory, read port driven by pixel_address, write port driven by the loader.
REQ-015 rgb_pixel SHALL equal mem[pixel_address] sampled one clock earlier (registered read, latency 1), independent of loader state.
REQ-016 Simultaneous read and write to the same address SHALL return the old contents (read-first).
REQ-017 FSM states SHALL be IDLE, BYTE_HI, BYTE_LO, CHECK, DONE.
REQ-018 IDLE: load_start=1 -> BYTE_HI, x=0, y=0, checksum=0; load_start outside IDLE SHALL be ignored.
REQ-019 byte_ready SHALL be 1 exactly in BYTE_HI, BYTE_LO, CHECK; a byte is accepted only when byte_valid && byte_ready.
REQ-020 BYTE_HI: accepted byte -> R = byte_data[3:0] latched (bits [7:4] ignored), -> BYTE_LO.
REQ-021 BYTE_LO: accepted byte -> mem[{y,x}] <= {R, byte_data[7:4], byte_data[3:0]} in the same edge, then x increments.
REQ-022 x SHALL wrap from IMG_W-1 to 0 with y incrementing; after pixel (IMG_W-1, IMG_H-1) the FSM SHALL go to CHECK if configured, else DONE; otherwise -> BYTE_HI.
REQ-023 Addresses with x >= IMG_W SHALL never be written.
REQ-024 No accepted byte (byte_valid=0) SHALL leave state, counters, memory unchanged; no timeout.
REQ-025 DONE SHALL last one cycle with load_done=1, then -> IDLE.
REQ-026 load_busy SHALL be 1 in BYTE_HI, BYTE_LO, CHECK, DONE and 0 in IDLE.
REQ-027 Checksum SHALL be the 8-bit XOR of all accepted pixel bytes (both bytes of every pixel).
REQ-028 load_error SHALL clear on accepted load_start and remain unchanged otherwise except per REQ-031.

Reset
REQ-029 On rst=0 at a clock edge: FSM -> IDLE, x=y=0, checksum=0, byte_ready=0, load_busy=0, load_done=0, load_error=0, rgb_pixel=12'h000.
REQ-030 Reset mid-load SHALL abort the load; memory contents (partially written) SHALL be retained, not cleared.

Configuration
REQ-031 Macro SPRITE_LOADER_CHECKSUM_EN defined: after the last pixel, CHECK accepts one trailer byte; trailer != checksum sets load_error=1; then -> DONE.
REQ-032 SPRITE_LOADER_CHECKSUM_EN undefined: CHECK unreachable, no trailer byte consumed, checksum logic absent, load_error tied to 0.

Verification
REQ-033 Reset with rst=0 for 2 cycles -> all outputs 0, byte_ready=0, FSM IDLE.
REQ-034 Full load of 48x64 pixels, pixel n = {n[3:0], n[7:4], n[11:8]} sent as bytes with random byte_valid gaps -> load_done pulses once after 6144 (+1 trailer) accepted bytes; reading {y,x} returns pixel y*48+x with 1-cycle latency.
REQ-035 Checksum enabled, trailer correct -> load_error=0; trailer flipped (xor 8'h01) -> load_error=1 held until next load_start.
REQ-036 Load in progress, rst=0 after 100 pixels, then reads of addresses 0..99 -> previously written values; address {1,0} (pixel 48) written, {0,48} never written.
REQ-037 Read address {0,5} while BYTE_LO write to {0,5} of 12'hABC over old 12'h123 -> rgb_pixel=12'h123 next cycle, 12'hABC the cycle after.
REQ-038 load_start pulsed while load_busy=1 -> ignored; counters and load_error unchanged.
